// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder.
// Ports (via modports):
//   master: drives A, B, Cin; observes S, Cout, V and their registered copies.
//   slave : the adder side, the reverse direction of master.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;
  logic [WIDTH-1:0] S_q;
  logic             Cout_q;
  logic             V_q;

  modport master (
    output A, B, Cin,
    input  S, Cout, V, S_q, Cout_q, V_q
  );

  modport slave (
    input  A, B, Cin,
    output S, Cout, V, S_q, Cout_q, V_q
  );

endinterface

// File: rtl/full_adder.sv
// Ripple-carry adder built from per-bit full-adder cells.
// Ports:
//   clk  - rising-edge clock for the registered copies
//   rst  - synchronous active-high clear of the registered copies
//   bus  - full_adder_if.slave: A, B, Cin in; combinational S, Cout, V out
//          (valid with clk idle) and one-cycle-delayed S_q, Cout_q, V_q out
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  full_adder_if.slave   bus
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             overflow;

  logic [WIDTH-1:0] s_d,    s_q;
  logic             cout_d, cout_q;
  logic             v_d,    v_q;

  // Per-bit full-adder cells chained from bit 0 upward
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = bus.Cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]     = bus.A[i] ^ bus.B[i] ^ carry[i];
      carry[i+1] = (bus.A[i] & bus.B[i]) | (bus.A[i] & carry[i]) | (bus.B[i] & carry[i]);
    end
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it
  assign overflow = carry[WIDTH-1] ^ carry[WIDTH];

  // Next values for the registered copies
  always_comb begin
    s_d    = sum;
    cout_d = carry[WIDTH];
    v_d    = overflow;
  end

  // Result register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      v_q    <= v_d;
    end
  end

  assign bus.S      = sum;
  assign bus.Cout   = carry[WIDTH];
  assign bus.V      = overflow;
  assign bus.S_q    = s_q;
  assign bus.Cout_q = cout_q;
  assign bus.V_q    = v_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH 1, 4 and 8.
module tb_full_adder;

  logic clk;
  logic clk_en;
  logic rst;

  int unsigned n_checks;
  int unsigned n_errors;

  full_adder_if #(.WIDTH(1)) w1 ();
  full_adder_if #(.WIDTH(4)) w4 ();
  full_adder_if #(.WIDTH(8)) w8 ();

  full_adder #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .bus(w1.slave));
  full_adder #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .bus(w4.slave));
  full_adder #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .bus(w8.slave));

  // Clock only runs while clk_en is set, so the first sweep sees an idle clock
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] s_tab, c_tab, v_tab;
  logic [2:0] vec;
  logic [7:0] ra, rb;
  logic       rc;
  logic [8:0] ref_sum;
  logic       ref_v;

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    w1.A = '0; w1.B = '0; w1.Cin = 1'b0;
    w4.A = '0; w4.B = '0; w4.Cin = 1'b0;
    w8.A = '0; w8.B = '0; w8.Cin = 1'b0;

    // WIDTH=1 truth table indexed by {A,B,Cin}
    s_tab = 8'b1001_0110;
    c_tab = 8'b1110_1000;
    v_tab = 8'b0100_0010;
    for (int i = 0; i < 8; i++) begin
      vec    = 3'(i);
      w1.A   = vec[2];
      w1.B   = vec[1];
      w1.Cin = vec[0];
      #100;
      check($sformatf("w1_s_%0d", i),    64'(w1.S),    64'(s_tab[i]));
      check($sformatf("w1_cout_%0d", i), 64'(w1.Cout), 64'(c_tab[i]));
      check($sformatf("w1_v_%0d", i),    64'(w1.V),    64'(v_tab[i]));
    end

    // Registered path: reset for two edges
    clk_en = 1'b1;
    rst    = 1'b1;
    tick();
    tick();
    check("w1_rst_sq",    64'(w1.S_q),    64'd0);
    check("w1_rst_coutq", 64'(w1.Cout_q), 64'd0);
    check("w1_rst_vq",    64'(w1.V_q),    64'd0);
    check("w4_rst_sq",    64'(w4.S_q),    64'd0);
    check("w8_rst_sq",    64'(w8.S_q),    64'd0);
    check("w8_rst_coutq", 64'(w8.Cout_q), 64'd0);

    // 1+1+0: combinational result ready before the edge, register one later
    rst = 1'b0;
    w1.A = 1'b1; w1.B = 1'b1; w1.Cin = 1'b0;
    #1;
    check("w1_pre_s",     64'(w1.S),      64'd0);
    check("w1_pre_cout",  64'(w1.Cout),   64'd1);
    check("w1_pre_coutq", 64'(w1.Cout_q), 64'd0);
    tick();
    check("w1_reg_sq",    64'(w1.S_q),    64'd0);
    check("w1_reg_coutq", 64'(w1.Cout_q), 64'd1);
    check("w1_reg_vq",    64'(w1.V_q),    64'd1);

    // Reset in mid-stream clears only the registers
    w1.A = 1'b1; w1.B = 1'b0; w1.Cin = 1'b1;
    tick();
    check("w1_ms_sq",    64'(w1.S_q),    64'd0);
    check("w1_ms_coutq", 64'(w1.Cout_q), 64'd1);
    rst = 1'b1;
    tick();
    check("w1_msr_sq",    64'(w1.S_q),    64'd0);
    check("w1_msr_coutq", 64'(w1.Cout_q), 64'd0);
    check("w1_msr_cout",  64'(w1.Cout),   64'd1);
    check("w1_msr_s",     64'(w1.S),      64'd0);
    rst = 1'b0;
    tick();
    check("w1_rel_coutq", 64'(w1.Cout_q), 64'd1);
    check("w1_rel_vq",    64'(w1.V_q),    64'd0);

    // WIDTH=4 wrap and overflow
    w4.A = 4'd15; w4.B = 4'd0; w4.Cin = 1'b1;
    #1;
    check("w4_wrap_s",    64'(w4.S),    64'd0);
    check("w4_wrap_cout", 64'(w4.Cout), 64'd1);
    check("w4_wrap_v",    64'(w4.V),    64'd0);
    tick();
    check("w4_wrap_coutq", 64'(w4.Cout_q), 64'd1);
    w4.A = 4'd7; w4.B = 4'd1; w4.Cin = 1'b0;
    #1;
    check("w4_ovf_s",    64'(w4.S),    64'd8);
    check("w4_ovf_cout", 64'(w4.Cout), 64'd0);
    check("w4_ovf_v",    64'(w4.V),    64'd1);
    tick();
    check("w4_ovf_sq", 64'(w4.S_q), 64'd8);
    check("w4_ovf_vq", 64'(w4.V_q), 64'd1);

    // WIDTH=8 directed corners
    w8.A = 8'd128; w8.B = 8'd128; w8.Cin = 1'b0;
    #1;
    check("w8_neg_s",    64'(w8.S),    64'd0);
    check("w8_neg_cout", 64'(w8.Cout), 64'd1);
    check("w8_neg_v",    64'(w8.V),    64'd1);
    w8.A = 8'd255; w8.B = 8'd255; w8.Cin = 1'b1;
    #1;
    check("w8_max_s",    64'(w8.S),    64'd255);
    check("w8_max_cout", 64'(w8.Cout), 64'd1);
    check("w8_max_v",    64'(w8.V),    64'd0);

    // WIDTH=8 random against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      rc = 1'($urandom_range(1, 0));
      w8.A = ra; w8.B = rb; w8.Cin = rc;
      ref_sum = 9'(ra) + 9'(rb) + 9'(rc);
      ref_v   = (ra[7] == rb[7]) && (ref_sum[7] != ra[7]);
      #1;
      check("w8_rnd_s",    64'(w8.S),    64'(ref_sum[7:0]));
      check("w8_rnd_cout", 64'(w8.Cout), 64'(ref_sum[8]));
      check("w8_rnd_v",    64'(w8.V),    64'(ref_v));
      tick();
      check("w8_rnd_sq",    64'(w8.S_q),    64'(ref_sum[7:0]));
      check("w8_rnd_coutq", 64'(w8.Cout_q), 64'(ref_sum[8]));
      check("w8_rnd_vq",    64'(w8.V_q),    64'(ref_v));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Binary full adder: sums operands A and B with carry-in Cin, producing sum S and carry-out Cout.
- Core outputs are purely combinational, so they are valid without a clock.
- A registered copy of the result is provided on the single clock domain for pipelined consumers.
- Default configuration is the classic 1-bit full adder cell; WIDTH scales it to a ripple-carry adder built from per-bit full-adder cells.

Parameters:
- WIDTH, 1, operand/sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  synchronous, active-high reset for the registered outputs.
- A  input  WIDTH  operand A, unsigned (two's complement for the V flags).
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in to bit 0.
- S  output  WIDTH  combinational sum, bits [WIDTH-1:0] of A+B+Cin.
- Cout  output  1  combinational carry-out, bit WIDTH of A+B+Cin.
- V  output  1  combinational signed overflow: carry into MSB XOR carry out of MSB.
- S_q  output  WIDTH  registered S.
- Cout_q  output  1  registered Cout.
- V_q  output  1  registered V.

Behaviour:
- Per-bit cell: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (a_i & c_i) | (b_i & c_i); c_0 = Cin; Cout = c_WIDTH.
- Arithmetic: {Cout,S} = A + B + Cin, computed modulo 2^(WIDTH+1). No saturation; wrap-around is by truncation to WIDTH bits, with the lost bit appearing on Cout.
- WIDTH=1 truth table, as (A,B,Cin) -> (S,Cout): 000->0,0; 001->1,0; 010->1,0; 011->0,1; 100->1,0; 101->0,1; 110->0,1; 111->1,1.
- Combinational outputs: S, Cout and V depend only on A, B and Cin.
  - Zero-cycle latency; they settle within the same time step as an input change.
  - They are unaffected by clk and rst, including when clk is held static or undriven.
  - No latches; every output is fully defined for every input combination.
- Registered outputs:
  - On each rising clk edge with rst=1: S_q<=0, Cout_q<=0, V_q<=0.
  - On each rising clk edge with rst=0: S_q<=S, Cout_q<=Cout, V_q<=V.
  - Latency is exactly 1 cycle, with no enable and no handshake.
  - Before the first clock edge the registered values are undefined. Benches must apply rst for at least one edge before checking them.
- Reset asserted mid-operation clears the registered outputs on the next edge only; combinational outputs continue tracking the inputs throughout.
- The WIDTH=1 signed overflow V equals Cin ^ Cout.
- Inputs X/Z are not required to be handled; all benches drive known values.

Test Plan:
- WIDTH=1 exhaustive sweep, clk idle: apply all 8 (A,B,Cin) combinations from 000 to 111, each held 100 ns -> S,Cout match the truth table (e.g. 011 -> S=0,Cout=1; 111 -> S=1,Cout=1).
- Registered path, WIDTH=1: assert rst for 2 edges -> S_q=0, Cout_q=0. Deassert and set A=1,B=1,Cin=0 -> one edge later S_q=0, Cout_q=1; the combinational S/Cout are already 0/1 before the edge.
- Reset mid-stream: with A=1,B=0,Cin=1 and S_q=0, Cout_q=1 held, assert rst for one edge -> S_q=0, Cout_q=0 while Cout stays 1. Deassert -> next edge restores Cout_q=1.
- WIDTH=4 wrap: A=15,B=0,Cin=1 -> S=0, Cout=1, V=0. A=7,B=1,Cin=0 -> S=8, Cout=0, V=1.
- WIDTH=8 random: 1000 random (A,B,Cin) vectors compared against the reference sum A+B+Cin -> {Cout,S} exact match; V matches sign-overflow rule; registered outputs match the prior cycle's combinational outputs.
